// File: rtl/mul_z_capture_if.sv
// Operand/product bundle between the datapath, the Booth multiplier and mul_z_capture.
// The z_ovf signal exists only when MUL_Z_OVF_EN is defined.
interface mul_z_capture_if;
   logic        start;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_p;
   logic        busy;
   logic        done;
   logic [31:0] zhi;
   logic [31:0] zlo;
   logic        z_zero;
   logic        z_neg;
`ifdef MUL_Z_OVF_EN
   logic        z_ovf;
`endif

   modport master (
      output start, a_in, b_in, mul_p,
      input  mul_a, mul_b, busy, done,
      input  zhi, zlo, z_zero, z_neg
`ifdef MUL_Z_OVF_EN
      , input z_ovf
`endif
   );

   modport slave (
      input  start, a_in, b_in, mul_p,
      output mul_a, mul_b, busy, done,
      output zhi, zlo, z_zero, z_neg
`ifdef MUL_Z_OVF_EN
      , output z_ovf
`endif
   );
endinterface

// File: rtl/mul_z_capture.sv
// Sequencer around the combinational Booth multiplier: latch, settle, capture into ZHI/ZLO.
// Optional z_ovf flag (product does not fit in 32-bit signed) enabled by MUL_Z_OVF_EN.
module mul_z_capture #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             clr,
   mul_z_capture_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_mul_a;
   logic [31:0] r_mul_b;
   logic [31:0] r_zhi;
   logic [31:0] r_zlo;
   logic        r_z_zero;
   logic        r_z_neg;
   logic        r_busy;
   logic        r_done;
   logic        w_accept;
`ifdef MUL_Z_OVF_EN
   logic        r_z_ovf;
   logic        w_ovf;

   // Top 33 bits must be a pure sign extension for the result to fit in 32 bits
   assign w_ovf = (|bus.mul_p[63:31]) & ~(&bus.mul_p[63:31]);
   assign bus.z_ovf = r_z_ovf;
`endif

   // A new request is taken from IDLE or directly from DONE (no bubble)
   assign w_accept = bus.start &&
                     (r_state == S_IDLE || r_state == S_DONE);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_mul_a  <= 32'd0;
         r_mul_b  <= 32'd0;
         r_zhi    <= 32'd0;
         r_zlo    <= 32'd0;
         r_z_zero <= 1'b0;
         r_z_neg  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef MUL_Z_OVF_EN
         r_z_ovf  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_accept) begin
                  r_mul_a <= bus.a_in;
                  r_mul_b <= bus.b_in;
                  r_cnt   <= CNT_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= S_SETTLE;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_SETTLE: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_zhi    <= bus.mul_p[63:32];
                  r_zlo    <= bus.mul_p[31:0];
                  r_z_zero <= (bus.mul_p == 64'd0);
                  r_z_neg  <= bus.mul_p[63];
`ifdef MUL_Z_OVF_EN
                  r_z_ovf  <= w_ovf;
`endif
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mul_a  = r_mul_a;
   assign bus.mul_b  = r_mul_b;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.zhi    = r_zhi;
   assign bus.zlo    = r_zlo;
   assign bus.z_zero = r_z_zero;
   assign bus.z_neg  = r_z_neg;

endmodule

// File: tb/tb_mul_z_capture.sv
// Self-checking bench for mul_z_capture with a behavioural multiplier and product model.
// Define MUL_Z_OVF_EN to also exercise the z_ovf flag.
module tb_mul_z_capture;

   localparam int P = 2;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mul_z_capture_if bus ();

   mul_z_capture #(.SETTLE_CYCLES(P)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Combinational Booth multiplier stand-in
   assign bus.mul_p = {{32{bus.mul_a[31]}}, bus.mul_a} *
                      {{32{bus.mul_b[31]}}, bus.mul_b};

   function automatic longint model_prod(input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
   endfunction

   function automatic bit model_ovf(input longint p);
      return (p > 64'sd2147483647) || (p < -64'sd2147483648);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one op; lat = edges from the start edge to done, -1 on timeout
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      tick();
      bus.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.a_in  = 32'd0;
      bus.b_in  = 32'd0;
      clr = 1'b1;
      tick();
      tick();
      #2 clr = 1'b0;
      checks++;
      if ({bus.mul_a, bus.mul_b} !== 64'd0) begin
         errors++;
         $display("FAIL reset_mul got %h/%h want 0/0", bus.mul_a, bus.mul_b);
      end
      checks++;
      if ({bus.zhi, bus.zlo} !== 64'd0) begin
         errors++;
         $display("FAIL reset_z got %h_%h want 0", bus.zhi, bus.zlo);
      end
      checks++;
      if ({bus.busy, bus.done, bus.z_zero, bus.z_neg} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got %b%b%b%b want 0000",
                  bus.busy, bus.done, bus.z_zero, bus.z_neg);
      end
`ifdef MUL_Z_OVF_EN
      checks++;
      if (bus.z_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0", bus.z_ovf);
      end
`endif
   endtask

   task automatic test_directed();
      logic [31:0] as [4] = '{32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] bs [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd12345, 32'd1};
      longint p;
      int lat;
      for (int k = 0; k < 4; k++) begin
         p = model_prod(as[k], bs[k]);
         do_op(as[k], bs[k], lat);
         checks++;
         if (lat !== P) begin
            errors++;
            $display("FAIL dir%0d_latency got %0d want %0d", k, lat, P);
         end
         checks++;
         if ({bus.zhi, bus.zlo} !== 64'(p)) begin
            errors++;
            $display("FAIL dir%0d_z got %h_%h want %h", k, bus.zhi, bus.zlo, p);
         end
         checks++;
         if ({bus.z_zero, bus.z_neg} !== {p == 0, p < 0}) begin
            errors++;
            $display("FAIL dir%0d_flags got zero=%b neg=%b want %b %b",
                     k, bus.z_zero, bus.z_neg, p == 0, p < 0);
         end
      end
   endtask

   task automatic test_start_ignored();
      int n;
      int dones;
      bus.start = 1'b1;
      bus.a_in  = 32'd5;
      bus.b_in  = 32'd6;
      tick();
      bus.a_in  = 32'd9;
      bus.b_in  = 32'd9;
      tick();
      bus.start = 1'b0;
      n = 1;
      while (bus.done !== 1'b1 && n < 20) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.mul_a !== 32'd5 || bus.mul_b !== 32'd6) begin
            errors++;
            $display("FAIL ign_settle busy=%b mul_a=%0d mul_b=%0d want 1 5 6",
                     bus.busy, bus.mul_a, bus.mul_b);
         end
         tick();
         n++;
      end
      checks++;
      if (n !== P || bus.zlo !== 32'd30 || bus.zhi !== 32'd0) begin
         errors++;
         $display("FAIL ign_result lat=%0d zlo=%0d zhi=%0d want %0d 30 0",
                  n, bus.zlo, bus.zhi, P);
      end
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.done === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ign_single_done extra=%0d busy=%b want 0 0", dones, bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int n;
      bus.start = 1'b1;
      bus.a_in  = 32'd2;
      bus.b_in  = 32'd3;
      tick();
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== P || bus.zlo !== 32'd6) begin
         errors++;
         $display("FAIL b2b_first lat=%0d zlo=%0d want %0d 6", lat, bus.zlo, P);
      end
      bus.a_in = 32'd4;
      bus.b_in = 32'd5;
      n = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.done === 1'b1) begin
            n = i;
            break;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (n !== P + 1 || bus.zlo !== 32'd20 || bus.zhi !== 32'd0) begin
         errors++;
         $display("FAIL b2b_second gap=%0d zlo=%0d zhi=%0d want %0d 20 0",
                  n, bus.zlo, bus.zhi, P + 1);
      end
      tick();
      tick();
   endtask

   task automatic test_async_clear();
      int lat;
      int dones;
      bus.start = 1'b1;
      bus.a_in  = 32'd100;
      bus.b_in  = 32'd200;
      tick();
      bus.start = 1'b0;
      #2 clr = 1'b1;
      #1;
      checks++;
      if ({bus.mul_a, bus.mul_b, bus.zhi, bus.zlo} !== 128'd0 ||
          {bus.busy, bus.done, bus.z_zero, bus.z_neg} !== 4'b0000) begin
         errors++;
         $display("FAIL clr_async mul=%h/%h z=%h_%h flags=%b%b%b%b want all 0",
                  bus.mul_a, bus.mul_b, bus.zhi, bus.zlo,
                  bus.busy, bus.done, bus.z_zero, bus.z_neg);
      end
      #2 clr = 1'b0;
      dones = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
      end
      checks++;
      if (dones !== 0 || bus.zlo !== 32'd0) begin
         errors++;
         $display("FAIL clr_discard activity=%0d zlo=%0d want 0 0", dones, bus.zlo);
      end
      do_op(32'd1, 32'd1, lat);
      checks++;
      if (lat !== P || bus.zlo !== 32'd1 || bus.zhi !== 32'd0) begin
         errors++;
         $display("FAIL clr_recover lat=%0d zlo=%0d want %0d 1", lat, bus.zlo, P);
      end
   endtask

`ifdef MUL_Z_OVF_EN
   task automatic test_ovf();
      logic [31:0] as [3] = '{32'h0001_0000, 32'd100, 32'hFFFF_FFFF};
      logic [31:0] bs [3] = '{32'h0001_0000, 32'd200, 32'd1};
      logic [63:0] zs [3] = '{64'h1_0000_0000, 64'd20000, 64'hFFFF_FFFF_FFFF_FFFF};
      bit          ov [3] = '{1'b1, 1'b0, 1'b0};
      int lat;
      for (int k = 0; k < 3; k++) begin
         do_op(as[k], bs[k], lat);
         checks++;
         if (lat !== P || {bus.zhi, bus.zlo} !== zs[k] || bus.z_ovf !== ov[k]) begin
            errors++;
            $display("FAIL ovf%0d lat=%0d z=%h_%h ovf=%b want %0d %h %b",
                     k, lat, bus.zhi, bus.zlo, bus.z_ovf, P, zs[k], ov[k]);
         end
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      longint p;
      int lat;
      for (int k = 0; k < 25; k++) begin
         a = $urandom;
         b = $urandom;
         if (k % 5 == 1) a = 32'($signed(16'($urandom)));
         if (k % 5 == 2) b = 32'd0;
         p = model_prod(a, b);
         do_op(a, b, lat);
         checks++;
         if (lat !== P || bus.mul_a !== a || bus.mul_b !== b) begin
            errors++;
            $display("FAIL rnd%0d_op lat=%0d mul=%h/%h want %0d %h/%h",
                     k, lat, bus.mul_a, bus.mul_b, P, a, b);
         end
         checks++;
         if ({bus.zhi, bus.zlo} !== 64'(p) ||
             {bus.z_zero, bus.z_neg} !== {p == 0, p < 0}) begin
            errors++;
            $display("FAIL rnd%0d_z got %h_%h z=%b n=%b want %h",
                     k, bus.zhi, bus.zlo, bus.z_zero, bus.z_neg, p);
         end
`ifdef MUL_Z_OVF_EN
         checks++;
         if (bus.z_ovf !== model_ovf(p)) begin
            errors++;
            $display("FAIL rnd%0d_ovf got %b want %b", k, bus.z_ovf, model_ovf(p));
         end
`endif
         if (k % 3 == 0) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_async_clear();
`ifdef MUL_Z_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
